// File: rtl/nanorv32_div_pkg.sv
// nanorv32_div_pkg: op/state encodings, word type and RISC-V special-case results
// shared by the iterative divider and its bus interface.
package nanorv32_div_pkg;
    localparam int NANORV32_WORD_MSB = 31;

    typedef logic [NANORV32_WORD_MSB:0] word_t;

    typedef enum logic [1:0] {
        NANORV32_DIV_OP_DIV  = 2'b00,
        NANORV32_DIV_OP_DIVU = 2'b01,
        NANORV32_DIV_OP_REM  = 2'b10,
        NANORV32_DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        NANORV32_DIV_STATE_IDLE = 2'd0,
        NANORV32_DIV_STATE_CALC = 2'd1,
        NANORV32_DIV_STATE_DONE = 2'd2
    } div_state_e;

    // b == 0 selects the divide-by-zero result, otherwise the signed-overflow result
    function automatic word_t div_special(logic is_rem, word_t a, word_t b);
        return (b == '0) ? (is_rem ? a : '1)
                         : (is_rem ? '0 : {1'b1, {NANORV32_WORD_MSB{1'b0}}});
    endfunction
endpackage

// File: rtl/nanorv32_div_if.sv
// nanorv32_div_if: start/valid handshake between the execute stage (master) and the divider (slave).
interface nanorv32_div_if;
    import nanorv32_div_pkg::*;

    logic       div_start;
    logic       div_kill;
    logic [1:0] div_op;
    word_t      div_dividend;
    word_t      div_divisor;
    logic       div_busy;
    logic       div_valid;
    word_t      div_res;

    modport master (
        output div_start, div_kill, div_op, div_dividend, div_divisor,
        input  div_busy, div_valid, div_res
    );

    modport slave (
        input  div_start, div_kill, div_op, div_dividend, div_divisor,
        output div_busy, div_valid, div_res
    );
endinterface

// File: rtl/nanorv32_div.sv
// nanorv32_div: iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define NANORV32_DIV_FAST_SPECIAL_EN to finish divide-by-zero and signed overflow in one cycle.
module nanorv32_div
    import nanorv32_div_pkg::*;
#(
    parameter int NANORV32_DIV_STEPS = 32
) (
    input logic clk,
    input logic rst_n,
    nanorv32_div_if.slave bus
);
    localparam logic [4:0] LAST = 5'(NANORV32_DIV_STEPS - 1);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    word_t       quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
    logic        is_rem_q, is_rem_d, qneg_q, qneg_d, rneg_q, rneg_d, div0_q, div0_d;

    logic        sgn_op, a_neg, b_neg, accept, last, fast, qbit, calc;
    word_t       a_mag, b_mag, quo_n, q_fin, r_fin;
    logic [33:0] sh, diff;
    logic [32:0] rem_n;

`ifdef NANORV32_DIV_FAST_SPECIAL_EN
    assign fast = accept && ((bus.div_divisor == '0) ||
                  (sgn_op && bus.div_dividend == 32'h8000_0000 && bus.div_divisor == '1));
`else
    assign fast = 1'b0;
`endif

    always_comb begin
        sgn_op   = (bus.div_op == NANORV32_DIV_OP_DIV) || (bus.div_op == NANORV32_DIV_OP_REM);
        a_neg    = sgn_op && bus.div_dividend[NANORV32_WORD_MSB];
        b_neg    = sgn_op && bus.div_divisor[NANORV32_WORD_MSB];
        a_mag    = a_neg ? -bus.div_dividend : bus.div_dividend;
        b_mag    = b_neg ? -bus.div_divisor : bus.div_divisor;
        calc     = state_q == NANORV32_DIV_STATE_CALC;
        accept   = bus.div_start && !bus.div_kill && !calc;
        last     = calc && (cnt_q == LAST);
        // trial subtract on the shifted remainder; bit 33 is the borrow
        sh       = {rem_q, quo_q[NANORV32_WORD_MSB]};
        diff     = sh - {2'b00, dvs_q};
        qbit     = !diff[33];
        rem_n    = qbit ? diff[32:0] : sh[32:0];
        quo_n    = {quo_q[NANORV32_WORD_MSB-1:0], qbit};
        q_fin    = div0_q ? '1 : (qneg_q ? -quo_n : quo_n);
        r_fin    = rneg_q ? -rem_n[NANORV32_WORD_MSB:0] : rem_n[NANORV32_WORD_MSB:0];
        state_d  = bus.div_kill ? NANORV32_DIV_STATE_IDLE
                 : accept ? (fast ? NANORV32_DIV_STATE_DONE : NANORV32_DIV_STATE_CALC)
                 : last ? NANORV32_DIV_STATE_DONE
                 : (state_q == NANORV32_DIV_STATE_DONE) ? NANORV32_DIV_STATE_IDLE
                 : state_q;
        cnt_d    = accept ? '0 : calc ? cnt_q + 5'd1 : cnt_q;
        rem_d    = accept ? '0 : calc ? rem_n : rem_q;
        quo_d    = accept ? a_mag : calc ? quo_n : quo_q;
        dvs_d    = accept ? b_mag : dvs_q;
        is_rem_d = accept ? bus.div_op[1] : is_rem_q;
        qneg_d   = accept ? a_neg ^ b_neg : qneg_q;
        rneg_d   = accept ? a_neg : rneg_q;
        div0_d   = accept ? (bus.div_divisor == '0) : div0_q;
        res_d    = fast ? div_special(bus.div_op[1], bus.div_dividend, bus.div_divisor)
                 : (last && !bus.div_kill) ? (is_rem_q ? r_fin : q_fin)
                 : res_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= NANORV32_DIV_STATE_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            res_q    <= '0;
            is_rem_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            res_q    <= res_d;
            is_rem_q <= is_rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
        end
    end

    assign bus.div_busy  = state_q == NANORV32_DIV_STATE_CALC;
    assign bus.div_valid = state_q == NANORV32_DIV_STATE_DONE;
    assign bus.div_res   = res_q;
endmodule

// File: tb/tb_nanorv32_div.sv
// tb_nanorv32_div: directed vector table, kill/back-to-back/reset sequences and random ops
// against an arithmetic reference model of RV32M division.
module tb_nanorv32_div;
    import nanorv32_div_pkg::*;

`ifdef NANORV32_DIV_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 33;
`endif
    localparam int NORM_LAT = 33;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        spec;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    nanorv32_div_if bus();
    nanorv32_div dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] ref_div(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        bus.div_start    = 1'b1;
        bus.div_op       = op;
        bus.div_dividend = a;
        bus.div_divisor  = b;
        @(posedge clk); #1;
        bus.div_start    = 1'b0;
        bus.div_op       = 2'($urandom());
        bus.div_dividend = $urandom();
        bus.div_divisor  = $urandom();
    endtask

    task automatic wait_valid(output int lat, output int busy_n);
        lat = 1;
        busy_n = 0;
        while (!bus.div_valid && lat < 100) begin
            busy_n += int'(bus.div_busy);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(string name, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                           logic [31:0] exp, int exp_lat);
        int lat, bn;
        issue(op, a, b);
        wait_valid(lat, bn);
        check({name, "_res"}, bus.div_res, exp);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(bn), 32'(exp_lat - 1));
        @(posedge clk); #1;
        check({name, "_pulse"}, 32'(bus.div_valid), 32'd0);
    endtask

    task automatic idle_no_valid(string name, int cycles);
        logic seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            seen |= bus.div_valid;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        vec_t vecs[13];
        int lat, bn;
        logic [1:0] op;
        logic [31:0] a, b;
        logic seen;

        vecs[0]  = '{NANORV32_DIV_OP_DIVU, 32'd100,        32'd7,        32'd14,       1'b0};
        vecs[1]  = '{NANORV32_DIV_OP_REMU, 32'd100,        32'd7,        32'd2,        1'b0};
        vecs[2]  = '{NANORV32_DIV_OP_DIV,  32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 1'b0};
        vecs[3]  = '{NANORV32_DIV_OP_REM,  32'hFFFFFF9C,   32'd7,        32'hFFFFFFFE, 1'b0};
        vecs[4]  = '{NANORV32_DIV_OP_DIV,  32'h12345678,   32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{NANORV32_DIV_OP_REM,  32'h12345678,   32'd0,        32'h12345678, 1'b1};
        vecs[6]  = '{NANORV32_DIV_OP_DIVU, 32'h12345678,   32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[7]  = '{NANORV32_DIV_OP_DIV,  32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[8]  = '{NANORV32_DIV_OP_REM,  32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[9]  = '{NANORV32_DIV_OP_DIVU, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[10] = '{NANORV32_DIV_OP_REMU, 32'hFFFFFFFF,   32'd1,        32'h00000000, 1'b0};
        vecs[11] = '{NANORV32_DIV_OP_REM,  32'd7,          32'hFFFFFFFE, 32'd1,        1'b0};
        vecs[12] = '{NANORV32_DIV_OP_DIV,  32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};

        bus.div_start = 1'b0;
        bus.div_kill = 1'b0;
        bus.div_op = 2'b00;
        bus.div_dividend = '0;
        bus.div_divisor = '0;

        #12;
        check("rst_busy", 32'(bus.div_busy), 32'd0);
        check("rst_valid", 32'(bus.div_valid), 32'd0);
        check("rst_res", bus.div_res, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 32'(bus.div_busy), 32'd0);

        for (int i = 0; i < 13; i++)
            run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                    vecs[i].spec ? SPEC_LAT : NORM_LAT);

        // kill sampled at the tenth edge after the start edge
        issue(NANORV32_DIV_OP_DIVU, 32'd1000, 32'd3);
        seen = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            seen |= bus.div_valid;
        end
        bus.div_kill = 1'b1;
        @(posedge clk); #1;
        bus.div_kill = 1'b0;
        check("kill_busy", 32'(bus.div_busy), 32'd0);
        check("kill_valid", 32'(bus.div_valid | seen), 32'd0);
        check("kill_res_held", bus.div_res, vecs[12].exp);
        @(posedge clk); #1;
        check("kill_no_valid", 32'(bus.div_valid), 32'd0);
        issue(NANORV32_DIV_OP_DIVU, 32'd1000, 32'd3);
        wait_valid(lat, bn);
        check("after_kill_lat", 32'(lat), 32'(NORM_LAT));
        check("after_kill_res", bus.div_res, 32'd333);
        @(posedge clk); #1;

        // back-to-back: second start held through the DONE cycle, third raised during CALC
        issue(NANORV32_DIV_OP_DIVU, 32'd5000, 32'd9);
        wait_valid(lat, bn);
        check("b2b_a_lat", 32'(lat), 32'(NORM_LAT));
        check("b2b_a_res", bus.div_res, 32'd555);
        issue(NANORV32_DIV_OP_DIV, 32'hFFFFEC78, 32'd9);
        check("b2b_b_accepted", 32'(bus.div_busy), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        bus.div_start = 1'b1;
        bus.div_op = NANORV32_DIV_OP_DIVU;
        bus.div_dividend = 32'd1;
        bus.div_divisor = 32'd1;
        @(posedge clk); #1;
        bus.div_start = 1'b0;
        wait_valid(lat, bn);
        check("b2b_b_lat", 32'(lat + 6), 32'(NORM_LAT));
        check("b2b_b_res", bus.div_res, 32'hFFFFFDD5);
        idle_no_valid("b2b_no_extra_valid", 40);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom();
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                3:       b = -32'($urandom_range(1, 300));
                4:       b = 32'($urandom_range(1, 65535));
                default: b = $urandom();
            endcase
            run_vec($sformatf("rnd%0d", i), op, a, b, ref_div(op, a, b),
                    ((b == 0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? SPEC_LAT : NORM_LAT);
        end

        // asynchronous reset in the middle of CALC, after a non-zero result
        run_vec("pre_rst", NANORV32_DIV_OP_DIVU, 32'd77, 32'd7, 32'd11, NORM_LAT);
        issue(NANORV32_DIV_OP_DIVU, 32'd99, 32'd5);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(bus.div_busy), 32'd0);
        check("async_rst_valid", 32'(bus.div_valid), 32'd0);
        check("async_rst_res", bus.div_res, 32'd0);
        #3;
        rst_n = 1'b1;
        idle_no_valid("post_rst_no_valid", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
